// File: rtl/riscv_base_defs.sv
// Shared widths and payload type for the integer write-back path.
// Imported by the write-back controller and its long-result FIFO.
package riscv_base_defs;

  localparam int REG_IDX_W = 5;
  localparam int XLEN      = 32;
  localparam int NUM_REGS  = 1 << REG_IDX_W;

  localparam logic [REG_IDX_W-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic [REG_IDX_W-1:0] rd;
    logic [XLEN-1:0]      value;
  } wb_entry_t;

  // One-hot mask of a register index with x0 suppressed.
  function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_IDX_W-1:0] idx);
    logic [NUM_REGS-1:0] m;
    m      = '0;
    m[idx] = 1'b1;
    m[0]   = 1'b0;
    return m;
  endfunction

endpackage

// File: rtl/riscv_base_wb_fifo.sv
// Registered FIFO for long-latency results (rd + value), no fall-through.
// The head entry is only visible one cycle after it was pushed.
module riscv_base_wb_fifo
  import riscv_base_defs::*;
#(
  parameter int DEPTH = 2
) (
  input  logic      clk_i,
  input  logic      rst_i,
  input  logic      push,
  input  wb_entry_t push_data,
  input  logic      pop,
  output wb_entry_t head,
  output logic      full,
  output logic      empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  wb_entry_t         mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CW-1:0]     count;
  logic              do_push;
  logic              do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // Pointers wrap naturally because DEPTH is a power of two.
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

endmodule

// File: rtl/riscv_base_wb_ctrl.sv
// Write-back controller: arbitrates rd0 between execute and buffered long
// results, tracks pending long destinations, stalls hazards, forwards rd0.
module riscv_base_wb_ctrl
  import riscv_base_defs::*;
#(
  parameter int FIFO_DEPTH = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 issue_valid_i,
  input  logic                 issue_long_i,
  input  logic [REG_IDX_W-1:0] issue_rd_i,
  input  logic [REG_IDX_W-1:0] issue_ra_i,
  input  logic [REG_IDX_W-1:0] issue_rb_i,
  output logic                 issue_stall_o,
  input  logic                 exec_valid_i,
  input  logic [REG_IDX_W-1:0] exec_rd_i,
  input  logic [XLEN-1:0]      exec_value_i,
  input  logic                 long_valid_i,
  input  logic [REG_IDX_W-1:0] long_rd_i,
  input  logic [XLEN-1:0]      long_value_i,
  output logic                 long_ready_o,
  output logic [REG_IDX_W-1:0] rd0_o,
  output logic [XLEN-1:0]      rd0_value_o,
  input  logic [XLEN-1:0]      ra_rf_value_i,
  input  logic [XLEN-1:0]      rb_rf_value_i,
  output logic [XLEN-1:0]      ra_value_o,
  output logic [XLEN-1:0]      rb_value_o
);

  logic [NUM_REGS-1:0] pending;
  logic [NUM_REGS-1:0] pending_nxt;
  wb_entry_t           fifo_in;
  wb_entry_t           fifo_head;
  logic                fifo_full;
  logic                fifo_empty;
  logic                fifo_push;
  logic                fifo_pop;
  logic                exec_wr;
  logic                head_commit;
  logic                raw_hit;
  logic                waw_hit;
  logic                set_en;

  assign long_ready_o = ~rst_i & ~fifo_full;
  assign fifo_push    = long_valid_i & long_ready_o;
  assign fifo_in      = '{rd: long_rd_i, value: long_value_i};

  riscv_base_wb_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .push      (fifo_push),
    .push_data (fifo_in),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Execute always wins the port; the FIFO head drains only on execute bubbles.
  assign exec_wr     = ~rst_i & exec_valid_i & (exec_rd_i != REG_ZERO);
  assign fifo_pop    = ~rst_i & ~exec_wr & ~fifo_empty;
  assign head_commit = fifo_pop & (fifo_head.rd != REG_ZERO);

  always_comb begin
    rd0_o       = REG_ZERO;
    rd0_value_o = '0;
    if (exec_wr) begin
      rd0_o       = exec_rd_i;
      rd0_value_o = exec_value_i;
    end else if (head_commit) begin
      rd0_o       = fifo_head.rd;
      rd0_value_o = fifo_head.value;
    end
  end

  assign raw_hit = ((issue_ra_i != REG_ZERO) & pending[issue_ra_i]) |
                   ((issue_rb_i != REG_ZERO) & pending[issue_rb_i]);
  assign waw_hit = (issue_rd_i != REG_ZERO) & pending[issue_rd_i];

  // A full FIFO also holds issue so execute bubbles appear and the FIFO drains.
  assign issue_stall_o = issue_valid_i & (raw_hit | waw_hit | fifo_full);

  assign set_en = issue_valid_i & issue_long_i & ~issue_stall_o &
                  (issue_rd_i != REG_ZERO);

  // Clear is applied before set so a same-cycle collision leaves the bit set.
  always_comb begin
    pending_nxt = pending;
    if (head_commit) pending_nxt = pending_nxt & ~reg_onehot(fifo_head.rd);
    if (set_en)      pending_nxt = pending_nxt | reg_onehot(issue_rd_i);
    pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) pending <= '0;
    else       pending <= pending_nxt;
  end

  assign ra_value_o = ((issue_ra_i != REG_ZERO) && (issue_ra_i == rd0_o)) ?
                      rd0_value_o : ra_rf_value_i;
  assign rb_value_o = ((issue_rb_i != REG_ZERO) && (issue_rb_i == rd0_o)) ?
                      rd0_value_o : rb_rf_value_i;

endmodule

// File: tb/tb_riscv_base_wb_ctrl.sv
// Bench for riscv_base_wb_ctrl: directed scenarios plus random traffic,
// all checked against a queue-based write-back/scoreboard reference model.
module tb_riscv_base_wb_ctrl;

  localparam int DEPTH = 2;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        issue_valid_i, issue_long_i;
  logic [4:0]  issue_rd_i, issue_ra_i, issue_rb_i;
  logic        issue_stall_o;
  logic        exec_valid_i;
  logic [4:0]  exec_rd_i;
  logic [31:0] exec_value_i;
  logic        long_valid_i;
  logic [4:0]  long_rd_i;
  logic [31:0] long_value_i;
  logic        long_ready_o;
  logic [4:0]  rd0_o;
  logic [31:0] rd0_value_o;
  logic [31:0] ra_rf_value_i, rb_rf_value_i;
  logic [31:0] ra_value_o, rb_value_o;

  riscv_base_wb_ctrl #(.FIFO_DEPTH(DEPTH)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .issue_valid_i (issue_valid_i),
    .issue_long_i  (issue_long_i),
    .issue_rd_i    (issue_rd_i),
    .issue_ra_i    (issue_ra_i),
    .issue_rb_i    (issue_rb_i),
    .issue_stall_o (issue_stall_o),
    .exec_valid_i  (exec_valid_i),
    .exec_rd_i     (exec_rd_i),
    .exec_value_i  (exec_value_i),
    .long_valid_i  (long_valid_i),
    .long_rd_i     (long_rd_i),
    .long_value_i  (long_value_i),
    .long_ready_o  (long_ready_o),
    .rd0_o         (rd0_o),
    .rd0_value_o   (rd0_value_o),
    .ra_rf_value_i (ra_rf_value_i),
    .rb_rf_value_i (rb_rf_value_i),
    .ra_value_o    (ra_value_o),
    .rb_value_o    (rb_value_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] val;
  } ent_t;

  ent_t q[$];
  bit   pend[32];
  int   n_cmp = 0;
  int   n_err = 0;

  bit          m_exec_wr, m_stall, m_ready;
  logic [4:0]  m_rd0;
  logic [31:0] m_val;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic idle();
    issue_valid_i = 0; issue_long_i = 0;
    issue_rd_i = 0; issue_ra_i = 0; issue_rb_i = 0;
    exec_valid_i = 0; exec_rd_i = 0; exec_value_i = 0;
    long_valid_i = 0; long_rd_i = 0; long_value_i = 0;
    ra_rf_value_i = 0; rb_rf_value_i = 0;
  endtask

  task automatic model_reset();
    q.delete();
    for (int i = 0; i < 32; i++) pend[i] = 0;
  endtask

  // Wait to mid-cycle, derive expectations from the model, compare all outputs.
  task automatic settle();
    logic [31:0] ea, eb;
    @(negedge clk_i);
    m_ready   = (q.size() < DEPTH);
    m_exec_wr = exec_valid_i && (exec_rd_i != 0);
    m_rd0 = 0; m_val = 0;
    if (m_exec_wr) begin
      m_rd0 = exec_rd_i; m_val = exec_value_i;
    end else if (q.size() > 0 && q[0].rd != 0) begin
      m_rd0 = q[0].rd; m_val = q[0].val;
    end
    m_stall = issue_valid_i && ((issue_ra_i != 0 && pend[issue_ra_i]) ||
                                (issue_rb_i != 0 && pend[issue_rb_i]) ||
                                (issue_rd_i != 0 && pend[issue_rd_i]) ||
                                (q.size() == DEPTH));
    ea = (issue_ra_i != 0 && issue_ra_i == m_rd0) ? m_val : ra_rf_value_i;
    eb = (issue_rb_i != 0 && issue_rb_i == m_rd0) ? m_val : rb_rf_value_i;
    chk("rd0", rd0_o, m_rd0);
    chk("rd0_value", rd0_value_o, m_val);
    chk("stall", issue_stall_o, m_stall);
    chk("long_ready", long_ready_o, m_ready);
    chk("ra_value", ra_value_o, ea);
    chk("rb_value", rb_value_o, eb);
  endtask

  // Clock edge: pop/clear first, then push and set, so a set of the same bit wins.
  task automatic advance();
    ent_t e;
    bit do_push;
    do_push = long_valid_i && m_ready;
    @(posedge clk_i);
    if (!m_exec_wr && q.size() > 0) begin
      e = q.pop_front();
      if (e.rd != 0) pend[e.rd] = 0;
    end
    if (do_push) q.push_back('{rd: long_rd_i, val: long_value_i});
    if (issue_valid_i && issue_long_i && !m_stall && issue_rd_i != 0) pend[issue_rd_i] = 1;
    #1;
  endtask

  initial begin
    idle();
    model_reset();
    #2;
    chk("rst_rd0", rd0_o, 0);
    chk("rst_val", rd0_value_o, 0);
    chk("rst_stall", issue_stall_o, 0);
    chk("rst_ready", long_ready_o, 0);
    @(posedge clk_i); #1;
    rst_i = 0;

    // Execute only
    idle(); exec_valid_i = 1; exec_rd_i = 5; exec_value_i = 32'h1234;
    settle(); chk("exec_rd5", rd0_o, 5); chk("exec_val", rd0_value_o, 32'h1234); advance();
    idle(); exec_valid_i = 1; exec_rd_i = 0; exec_value_i = 32'h77;
    settle(); chk("exec_rd0_nowrite", rd0_o, 0); advance();

    // Long collision with execute
    idle(); issue_valid_i = 1; issue_long_i = 1; issue_rd_i = 7; settle(); advance();
    idle(); exec_valid_i = 1; exec_rd_i = 3; exec_value_i = 32'h33;
    long_valid_i = 1; long_rd_i = 7; long_value_i = 32'hAAAA;
    settle(); chk("coll_rd3a", rd0_o, 3); advance();
    idle(); exec_valid_i = 1; exec_rd_i = 3; exec_value_i = 32'h34;
    settle(); chk("coll_rd3b", rd0_o, 3); advance();
    idle(); issue_valid_i = 1; issue_ra_i = 7;
    settle(); chk("coll_rd7", rd0_o, 7); chk("coll_val7", rd0_value_o, 32'hAAAA);
    chk("coll_stall_commit", issue_stall_o, 1); advance();
    settle(); chk("coll_pend7_clear", issue_stall_o, 0); advance();

    // RAW stall on x9
    idle(); issue_valid_i = 1; issue_long_i = 1; issue_rd_i = 9; settle(); advance();
    idle(); issue_valid_i = 1; issue_ra_i = 9; issue_rd_i = 2;
    settle(); chk("raw_stall", issue_stall_o, 1); advance();
    long_valid_i = 1; long_rd_i = 9; long_value_i = 32'h99;
    settle(); chk("raw_stall_push", issue_stall_o, 1); advance();
    long_valid_i = 0; ra_rf_value_i = 32'h1;
    settle(); chk("raw_fwd", ra_value_o, 32'h99); chk("raw_stall_commit", issue_stall_o, 1); advance();
    settle(); chk("raw_release", issue_stall_o, 0); advance();

    // FIFO full while execute is busy every cycle
    idle(); issue_valid_i = 1; issue_long_i = 1; issue_rd_i = 10; settle(); advance();
    issue_rd_i = 11; settle(); advance();
    idle(); exec_valid_i = 1; exec_rd_i = 1; long_valid_i = 1; long_rd_i = 10; long_value_i = 32'hA0;
    settle(); advance();
    long_rd_i = 11; long_value_i = 32'hB0; settle(); advance();
    long_valid_i = 0; issue_valid_i = 1; issue_rd_i = 20; issue_ra_i = 21;
    settle(); chk("full_ready", long_ready_o, 0); chk("full_stall", issue_stall_o, 1); advance();
    idle(); settle(); chk("drain_first", rd0_o, 10); advance();
    settle(); chk("drain_second", rd0_o, 11); chk("drain_val", rd0_value_o, 32'hB0); advance();

    // Forwarding
    idle(); exec_valid_i = 1; exec_rd_i = 4; exec_value_i = 32'hDEAD; issue_ra_i = 4;
    settle(); chk("fwd_ra4", ra_value_o, 32'hDEAD); advance();
    issue_ra_i = 0; ra_rf_value_i = 32'h55;
    settle(); chk("fwd_ra0", ra_value_o, 32'h55); advance();

    // Async reset with one buffered entry and pending x12
    idle(); issue_valid_i = 1; issue_long_i = 1; issue_rd_i = 12; settle(); advance();
    idle(); exec_valid_i = 1; exec_rd_i = 2; long_valid_i = 1; long_rd_i = 12; long_value_i = 32'hC12;
    settle(); advance();
    long_valid_i = 0; #2;
    rst_i = 1; #1;
    chk("arst_rd0", rd0_o, 0);
    chk("arst_val", rd0_value_o, 0);
    chk("arst_ready", long_ready_o, 0);
    model_reset();
    @(posedge clk_i); #1;
    rst_i = 0;
    idle(); issue_valid_i = 1; issue_ra_i = 12;
    settle(); chk("arst_no_x12", rd0_o, 0); chk("arst_no_stall", issue_stall_o, 0); advance();
    settle(); advance();

    // Random traffic over a small register window to provoke hazards
    for (int c = 0; c < 800; c++) begin
      issue_valid_i = ($urandom_range(0, 3) != 0);
      issue_long_i  = ($urandom_range(0, 2) == 0);
      issue_rd_i    = 5'($urandom_range(0, 15));
      issue_ra_i    = 5'($urandom_range(0, 15));
      issue_rb_i    = 5'($urandom_range(0, 15));
      exec_valid_i  = ($urandom_range(0, 1) == 0);
      exec_rd_i     = 5'($urandom_range(0, 15));
      exec_value_i  = $urandom;
      long_valid_i  = ($urandom_range(0, 2) == 0);
      long_rd_i     = 5'($urandom_range(0, 15));
      long_value_i  = $urandom;
      ra_rf_value_i = $urandom;
      rb_rf_value_i = $urandom;
      settle();
      advance();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/riscv_base_wb_ctrl.md
Name: riscv_base_wb_ctrl

Overview:
Write-back controller and scoreboard for the 2-read/1-write integer register file.
- Shares the single rd0 write port between the single-cycle execute result and a multi-cycle long-latency unit (load/mul/div).
- Buffers long results in a small FIFO and tracks pending long destinations.
- Stalls issue on RAW/WAW hazards against pending registers.
- Forwards the same-cycle write value onto the read operands.

Parameters:
- FIFO_DEPTH, 2, long-result buffer entries; power of two, minimum 2.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset; asynchronous, active-high
- issue_valid_i  in  1  instruction at issue stage
- issue_long_i  in  1  issuing instruction is long-latency
- issue_rd_i  in  5  destination of issuing instruction
- issue_ra_i  in  5  source A of issuing instruction
- issue_rb_i  in  5  source B of issuing instruction
- issue_stall_o  out  1  hold issue this cycle
- exec_valid_i  in  1  execute write-back valid; no backpressure
- exec_rd_i  in  5  execute destination
- exec_value_i  in  32  execute result
- long_valid_i  in  1  long unit result valid
- long_rd_i  in  5  long unit destination
- long_value_i  in  32  long unit result
- long_ready_o  out  1  FIFO can accept a long result
- rd0_o  out  5  register file write index (0 = no write)
- rd0_value_o  out  32  register file write data
- ra_rf_value_i  in  32  register file port A read data
- rb_rf_value_i  in  32  register file port B read data
- ra_value_o  out  32  forwarded operand A
- rb_value_o  out  32  forwarded operand B

Behaviour:
Reset (async, rst_i=1):
- FIFO empty, pending mask = 0.
- rd0_o = 0, rd0_value_o = 0, issue_stall_o = 0, long_ready_o = 0.

Long-result FIFO:
- Push when long_valid_i & long_ready_o.
- long_ready_o = ~rst_i & ~full; registered count, no same-cycle pop credit.

Write port arbitration (combinational, one write per cycle):
- Execute has absolute priority when exec_valid_i & exec_rd_i != 0: rd0_o = exec_rd_i, rd0_value_o = exec_value_i.
- Otherwise, if FIFO is non-empty, pop the head: rd0_o = head rd, rd0_value_o = head value. A head with rd = 0 is popped with no write (rd0_o = 0).
- Otherwise rd0_o = 0, rd0_value_o = 0.
- Latency: execute result written at the next edge. A long result is written ≥1 cycle after push (FIFO is registered, no fall-through).

Scoreboard:
- 32-bit pending mask; bit 0 is forced to 0.
- Set pending[issue_rd_i] on issue_valid_i & issue_long_i & ~issue_stall_o & issue_rd_i != 0.
- Clear pending[rd] when a FIFO head with that rd commits.
- Set and clear of the same bit in the same cycle: set wins. This cannot arise legally, since WAW stall blocks it, but RTL must still implement set-wins.

Issue stall (issue_stall_o = issue_valid_i & any of):
- pending[issue_ra_i] or pending[issue_rb_i] (RAW), with index 0 ignored.
- pending[issue_rd_i] (WAW), with rd 0 ignored.
- FIFO full. This guarantees execute bubbles so the FIFO drains and long results are never starved.

Forwarding:
- ra_value_o = (issue_ra_i != 0 & issue_ra_i == rd0_o) ? rd0_value_o : ra_rf_value_i. Port B identical.
- Index 0 always reads through unchanged.

Boundary conditions:
- Push and pop in the same cycle on a full FIFO is not allowed (ready=0).
- Count wraps correctly at FIFO_DEPTH.
- Reset mid-operation discards FIFO contents and pending bits. The long unit is reset by the same rst_i.

Decomposition:
- Shared package riscv_base_defs: REG_IDX_W = 5, XLEN = 32, REG_ZERO = 5'd0.
- One sub-module, riscv_base_wb_fifo: parameterised sync FIFO with push/pop/full/empty, rd+value payload, async active-high reset.

Test Plan:
- Exec only: exec_valid=1, rd=5, value=0x1234 → rd0_o=5, value 0x1234. Next cycle, with the register file, a read of x5 returns 0x1234. exec rd=0 → rd0_o=0.
- Long collision: push long rd=7 = 0xAAAA while exec writes rd=3 for 2 cycles → rd0_o=3 twice, then rd0_o=7 = 0xAAAA when exec idles. pending[7] clears on that cycle.
- RAW stall: issue long rd=9, then issue ra=9 → issue_stall_o=1 until x9 commits. Stall drops in the cycle after commit; forward provides the value on the commit cycle.
- FIFO full: push 2 long results while exec is valid every cycle → long_ready_o=0 and issue_stall_o=1. On the first exec bubble the FIFO drains in order.
- Forward: rd0_o=4 = 0xDEAD with issue_ra=4, ra_rf=0 → ra_value_o=0xDEAD. With issue_ra=0 → ra_value_o = ra_rf_value_i.
- Async reset with 1 FIFO entry and pending[12]=1 → outputs zero immediately. After release, no write of x12 occurs and there is no stall on ra=12.
